// File: rtl/note_player.sv
// Square-wave note player: plays a note for a number of beats, emits 16-bit samples.
// Latency: new_note -> busy 1 cycle; last counted beat -> note_done 2 cycles; sample_tick -> sample_valid 1 cycle.
// Backpressure: none; strobes are consumed when they arrive, play=0 pauses beat counting and phase.
//
// Ports:
//   clk, reset (sync, active-low)     - clock and reset
//   play                              - 1 = run, 0 = pause (beats ignored, output muted)
//   new_note, note, duration          - strobe that loads a note index (0 = rest) and its length in beats
//   beat, sample_tick                 - beat tick and 48 kHz sample request strobes
//   note_done                         - one-cycle pulse when the current note has finished
//   sample_out, sample_valid          - signed sample and its one-cycle update pulse
//   busy                              - high while a note is playing or finishing
module note_player #(
    parameter int PHASE_BITS = 20,
    parameter int AMPL       = 8192
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               play,
    input  logic               new_note,
    input  logic [5:0]         note,
    input  logic [5:0]         duration,
    input  logic               beat,
    input  logic               sample_tick,
    output logic               note_done,
    output logic signed [15:0] sample_out,
    output logic               sample_valid,
    output logic               busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_FINISH
    } state_t;

    localparam logic signed [15:0] C_POS = 16'(AMPL);
    localparam logic signed [15:0] C_NEG = -C_POS;

    // Phase increment for note n: 440 Hz at n=49, equal temperament, 48 kHz sample rate.
    // Only ever evaluated at elaboration to fill the constant table below.
    function automatic logic [PHASE_BITS-1:0] step_calc(input int n);
        real r;
        if (n == 0) begin
            step_calc = '0;
        end else begin
            r = (2.0 ** PHASE_BITS) * 440.0 * (2.0 ** (real'(n - 49) / 12.0)) / 48000.0;
            step_calc = PHASE_BITS'($rtoi(r + 0.5));
        end
    endfunction

    logic [PHASE_BITS-1:0] w_step [64];

    for (genvar g = 0; g < 64; g++) begin : g_step
        localparam logic [PHASE_BITS-1:0] C_STEP = step_calc(g);
        assign w_step[g] = C_STEP;
    end

    state_t                r_state;
    logic [5:0]            r_note;
    logic [5:0]            r_cnt;     // beats still to be counted; loaded with the note's duration
    logic [PHASE_BITS-1:0] r_phase;
    logic                  r_done;
    logic signed [15:0]    r_sample;
    logic                  r_valid;
    logic                  r_busy;

    logic signed [15:0]    w_sample_nxt;

    // Sample value from the pre-update phase of the current cycle.
    always_comb begin
        w_sample_nxt = '0;
        if (r_state == S_PLAY && play && r_note != 6'd0) begin
            w_sample_nxt = r_phase[PHASE_BITS-1] ? C_NEG : C_POS;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_note   <= '0;
            r_cnt    <= '0;
            r_phase  <= '0;
            r_done   <= 1'b0;
            r_sample <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_valid <= sample_tick;
            if (sample_tick) begin
                r_sample <= w_sample_nxt;
            end
            r_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (new_note) begin
                        r_note  <= note;
                        r_cnt   <= duration;
                        r_phase <= '0;
                        r_state <= S_PLAY;
                        r_busy  <= 1'b1;
                    end
                end
                S_PLAY: begin
                    if (new_note) begin
                        // Abort and restart: no note_done for the replaced note.
                        r_note  <= note;
                        r_cnt   <= duration;
                        r_phase <= '0;
                    end else begin
                        if (sample_tick && play) begin
                            r_phase <= r_phase + w_step[r_note];
                        end
                        // A zero count means the last beat was taken on an earlier edge (or the
                        // duration was 0), which gives the two-cycle beat-to-done latency.
                        if (r_cnt == 6'd0) begin
                            r_state <= S_FINISH;
                            r_done  <= 1'b1;
                        end else if (beat && play) begin
                            r_cnt <= r_cnt - 6'd1;
                        end
                    end
                end
                S_FINISH: begin
                    if (new_note) begin
                        r_note  <= note;
                        r_cnt   <= duration;
                        r_phase <= '0;
                        r_state <= S_PLAY;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign note_done    = r_done;
    assign sample_out   = r_sample;
    assign sample_valid = r_valid;
    assign busy         = r_busy;

endmodule

// File: tb/tb_note_player.sv
module tb_note_player;

    localparam int PB   = 20;
    localparam int AMPL = 8192;
    localparam longint HALF = 64'd1 << (PB - 1);
    localparam longint FULL = 64'd1 << PB;

    logic               clk = 1'b0;
    logic               reset;
    logic               play;
    logic               new_note;
    logic [5:0]         note;
    logic [5:0]         duration;
    logic               beat;
    logic               sample_tick;
    logic               note_done;
    logic signed [15:0] sample_out;
    logic               sample_valid;
    logic               busy;

    note_player #(.PHASE_BITS(PB), .AMPL(AMPL)) dut (
        .clk          (clk),
        .reset        (reset),
        .play         (play),
        .new_note     (new_note),
        .note         (note),
        .duration     (duration),
        .beat         (beat),
        .sample_tick  (sample_tick),
        .note_done    (note_done),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_cyc = 0;

    // Reference model: 0 = no note, 1 = note sounding, 2 = note just ended
    int     m_mode  = 0;
    int     m_note  = 0;
    int     m_left  = 0;
    longint m_phase = 0;
    int     e_sample = 0;
    bit     e_valid  = 1'b0;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, n_cyc, obs, exp);
        end
    endtask

    function automatic longint ref_step(input int n);
        real hz;
        if (n == 0) return 0;
        hz = 440.0 * $pow(2.0, real'(n - 49) / 12.0);
        return longint'($rtoi(hz * real'(FULL) / 48000.0 + 0.5));
    endfunction

    task automatic model_edge(input bit rst, input bit pl, input bit nn, input int nt, input int du,
                              input bit bt, input bit tk);
        if (!rst) begin
            m_mode = 0; m_note = 0; m_left = 0; m_phase = 0;
            e_sample = 0; e_valid = 1'b0;
            return;
        end
        e_valid = tk;
        if (tk) begin
            if (m_mode == 1 && pl && m_note != 0) e_sample = (m_phase >= HALF) ? -AMPL : AMPL;
            else                                  e_sample = 0;
        end
        if (nn) begin
            m_note = nt; m_left = du; m_phase = 0; m_mode = 1;
        end else if (m_mode == 1) begin
            if (tk && pl) m_phase = (m_phase + ref_step(m_note)) % FULL;
            if (m_left == 0)        m_mode = 2;
            else if (bt && pl)      m_left--;
        end else if (m_mode == 2) begin
            m_mode = 0;
        end
    endtask

    task automatic cyc(input bit rst, input bit pl, input bit nn, input int nt, input int du,
                       input bit bt, input bit tk);
        reset = rst; play = pl; new_note = nn; note = 6'(nt); duration = 6'(du);
        beat = bt; sample_tick = tk;
        @(posedge clk);
        model_edge(rst, pl, nn, nt, du, bt, tk);
        #1;
        n_cyc++;
        check("busy",         32'(busy),         32'(m_mode != 0));
        check("note_done",    32'(note_done),    32'(m_mode == 2));
        check("sample_valid", 32'(sample_valid), 32'(e_valid));
        check("sample_out",   32'(sample_out),   32'(e_sample));
    endtask

    initial begin
        bit pl;
        bit dense;
        int bdiv;
        // Reset and quiet period after release
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 12, 4, 1, 1);
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0, 1, 0);

        // note 49, three beats, sample every cycle
        cyc(1, 1, 1, 49, 3, 0, 0);
        for (int i = 0; i < 70; i++) cyc(1, 1, 0, 0, 0, (i % 20) == 5, 1);

        // zero-duration note needs no beat
        cyc(1, 1, 1, 10, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 0, 0, 1);

        // rest note
        cyc(1, 1, 1, 0, 2, 0, 1);
        for (int i = 0; i < 10; i++) cyc(1, 1, 0, 0, 0, (i % 4) == 1, 1);

        // pause with two beats left
        cyc(1, 1, 1, 60, 4, 0, 1);
        cyc(1, 1, 0, 0, 0, 1, 1);
        cyc(1, 1, 0, 0, 0, 1, 1);
        for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, 0, (i % 2) == 0, 1);
        for (int i = 0; i < 12; i++) cyc(1, 1, 0, 0, 0, (i % 4) == 0, 1);

        // new note in the finishing cycle
        cyc(1, 1, 1, 5, 1, 0, 1);
        for (int i = 0; i < 20 && m_mode != 2; i++) cyc(1, 1, 0, 0, 0, 1, 1);
        cyc(1, 1, 1, 40, 2, 0, 1);
        for (int i = 0; i < 12; i++) cyc(1, 1, 0, 0, 0, (i % 3) == 2, 1);

        // reset mid-note with new_note in the same cycle
        cyc(1, 1, 1, 55, 6, 0, 1);
        for (int i = 0; i < 30; i++) cyc(1, 1, 0, 0, 0, 0, 1);
        cyc(0, 1, 1, 20, 3, 1, 1);
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0, 1, 0);

        // Randomized traffic
        pl = 1'b1; dense = 1'b1; bdiv = 8;
        for (int i = 0; i < 16000; i++) begin
            bit nn;
            if (i % 200 == 0) begin
                dense = $urandom_range(0, 1) == 1;
                bdiv  = ($urandom_range(0, 1) == 1) ? 8 : 32;
            end
            if ($urandom_range(0, 49) == 0) pl = ~pl;
            case (m_mode)
                0:       nn = $urandom_range(0, 2) == 0;
                2:       nn = $urandom_range(0, 1) == 0;
                default: nn = $urandom_range(0, 99) == 0;
            endcase
            cyc($urandom_range(0, 2999) != 0, pl, nn,
                int'($urandom_range(0, 63)), int'($urandom_range(0, 7)),
                $urandom_range(0, bdiv - 1) == 0,
                dense ? 1'b1 : ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
